// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: data memory loads/stores and MEM/WB register
module memory_access #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_REG-1:0]  i_write_reg,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_mem2reg,
  input  logic               i_regWrite,
  input  logic [NB_ADDR-1:0] i_du_addr,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_du_data
);

  localparam int         DEPTH  = 2**NB_ADDR;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  logic               hold;
  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic               is_access;
  logic               is_load;
  logic               lane_bad;
  logic               misaligned;
  logic               do_store;
  logic [NB_DATA-1:0] rd_word;
  logic [NB_DATA-1:0] lane_data;
  logic [NB_DATA-1:0] load_ext;
  logic [NB_DATA-1:0] store_rep;
  logic [NB_DATA-1:0] store_word;
  logic [3:0]         byte_en;

  logic [NB_DATA-1:0] read_data_d, read_data_q;
  logic [NB_DATA-1:0] alu_result_d, alu_result_q;
  logic [NB_REG-1:0]  write_reg_d, write_reg_q;
  logic               mem2reg_d, mem2reg_q;
  logic               reg_write_d, reg_write_q;
  logic               misaligned_d, misaligned_q;
  logic [NB_DATA-1:0] du_data_q;

  // Address bits above the memory depth are ignored: addresses wrap.
  logic unused_upper;
  assign unused_upper = ^i_result[NB_DATA-1:NB_ADDR+2];

  assign hold       = i_stall | i_halt;
  assign word_idx   = i_result[NB_ADDR+1:2];
  assign lane       = i_result[1:0];
  assign is_access  = i_memRead | i_memWrite;
  assign is_load    = i_memRead & ~i_memWrite;
  assign misaligned = is_access & lane_bad;
  // Reset low at the edge discards the pending write.
  assign do_store   = i_memWrite & ~misaligned & ~hold & i_rst_n;
  assign rd_word    = mem_q[word_idx];
  assign lane_data  = rd_word >> {lane, 3'b000};

  // Alignment rule per access width; reserved width follows word rules.
  always_comb begin
    lane_bad = |lane;
    case (i_width)
      W_BYTE:  lane_bad = 1'b0;
      W_HALF:  lane_bad = lane[0];
      default: lane_bad = |lane;
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    load_ext = rd_word;
    case (i_width)
      W_BYTE:  load_ext = {{(NB_DATA-8){i_sign_flag & lane_data[7]}}, lane_data[7:0]};
      W_HALF:  load_ext = {{(NB_DATA-16){i_sign_flag & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = rd_word;
    endcase
  end

  // Store merge: replicate the store data across lanes, keep unselected lanes.
  always_comb begin
    byte_en    = 4'b1111;
    store_rep  = i_data4Mem;
    store_word = rd_word;
    case (i_width)
      W_BYTE: begin
        byte_en   = 4'b0001 << lane;
        store_rep = {4{i_data4Mem[7:0]}};
      end
      W_HALF: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{i_data4Mem[15:0]}};
      end
      default: ;
    endcase
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) store_word[8*b +: 8] = store_rep[8*b +: 8];
    end
  end

  // MEM/WB next state: hold everything while stalled or halted.
  always_comb begin
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    mem2reg_d    = mem2reg_q;
    reg_write_d  = reg_write_q;
    misaligned_d = misaligned_q;
    if (!hold) begin
      read_data_d  = (is_load && !misaligned) ? load_ext : '0;
      alu_result_d = i_result;
      write_reg_d  = i_write_reg;
      mem2reg_d    = i_mem2reg;
      reg_write_d  = i_regWrite & ~(is_load & misaligned);
      misaligned_d = misaligned;
    end
  end

  // Data memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_store) mem_q[word_idx] <= store_word;
  end

  // MEM/WB pipeline register and debug read port.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      mem2reg_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      du_data_q    <= '0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      mem2reg_q    <= mem2reg_d;
      reg_write_q  <= reg_write_d;
      misaligned_q <= misaligned_d;
      du_data_q    <= mem_q[i_du_addr];
    end
  end

  assign o_read_data  = read_data_q;
  assign o_alu_result = alu_result_q;
  assign o_write_reg  = write_reg_q;
  assign o_mem2reg    = mem2reg_q;
  assign o_regWrite   = reg_write_q;
  assign o_misaligned = misaligned_q;
  assign o_du_data    = du_data_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - self-checking bench for memory_access
module tb_memory_access;

  logic        clk;
  logic        rst_n;
  logic        stall, halt;
  logic [31:0] result, data4mem;
  logic [4:0]  wreg;
  logic [1:0]  width;
  logic        sign, mrd, mwr, m2r, rw;
  logic [7:0]  du_addr;
  logic [31:0] o_rd, o_alu, o_du;
  logic [4:0]  o_wreg;
  logic        o_m2r, o_rw, o_mis;

  int n_chk  = 0;
  int n_pass = 0;

  memory_access dut (
    .clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_halt(halt),
    .i_result(result), .i_data4Mem(data4mem), .i_write_reg(wreg),
    .i_width(width), .i_sign_flag(sign), .i_memRead(mrd), .i_memWrite(mwr),
    .i_mem2reg(m2r), .i_regWrite(rw), .i_du_addr(du_addr),
    .o_read_data(o_rd), .o_alu_result(o_alu), .o_write_reg(o_wreg),
    .o_mem2reg(o_m2r), .o_regWrite(o_rw), .o_misaligned(o_mis), .o_du_data(o_du)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  // Byte-addressed memory model (1 KiB) with per-byte "known" flags.
  logic [7:0]  mm [0:1023];
  bit          kn [0:1023];
  logic [31:0] e_rd, e_alu, e_du;
  logic [4:0]  e_wreg;
  logic        e_m2r, e_rw, e_mis;
  bit          e_rd_k, e_du_k;
  int          ba, sz, da;
  bit          mis, kk;
  logic [31:0] v;

  initial for (int i = 0; i < 1024; i++) kn[i] = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rd = 0; e_alu = 0; e_wreg = 0; e_m2r = 0; e_rw = 0; e_mis = 0; e_du = 0;
      e_rd_k = 1; e_du_k = 1;
    end else begin
      da = int'(du_addr) * 4;
      e_du   = {mm[da+3], mm[da+2], mm[da+1], mm[da]};
      e_du_k = kn[da] && kn[da+1] && kn[da+2] && kn[da+3];
      if (!(stall || halt)) begin
        sz  = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
        ba  = int'(result & 32'h3FF);
        mis = (mrd || mwr) && (ba % sz != 0);
        e_rd = 0; e_rd_k = 1;
        if (mrd && !mwr && !mis) begin
          v = 0; kk = 1;
          for (int j = 0; j < sz; j++) begin
            v  = v | (32'(mm[ba+j]) << (8*j));
            kk = kk && kn[ba+j];
          end
          if (sz == 1 && sign && v[7])  v = v | 32'hFFFFFF00;
          if (sz == 2 && sign && v[15]) v = v | 32'hFFFF0000;
          e_rd = v; e_rd_k = kk;
        end
        if (mwr && !mis) begin
          for (int j = 0; j < sz; j++) begin
            mm[ba+j] = 8'(data4mem >> (8*j));
            kn[ba+j] = 1;
          end
        end
        e_alu = result; e_wreg = wreg; e_m2r = m2r; e_mis = mis;
        e_rw  = rw && !(mrd && !mwr && mis);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (e_rd_k) chk("cyc_read_data", o_rd, e_rd);
    if (e_du_k) chk("cyc_du_data", o_du, e_du);
    chk("cyc_alu_result", o_alu, e_alu);
    chk("cyc_write_reg", 32'(o_wreg), 32'(e_wreg));
    chk("cyc_mem2reg", 32'(o_m2r), 32'(e_m2r));
    chk("cyc_regWrite", 32'(o_rw), 32'(e_rw));
    chk("cyc_misaligned", 32'(o_mis), 32'(e_mis));
  end

  task automatic set_op(input bit r, input bit w, input logic [1:0] wd, input bit sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                        input bit mr, input bit rwi);
    mrd = r; mwr = w; width = wd; sign = sg; result = a; data4mem = d;
    wreg = dst; m2r = mr; rw = rwi;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] wd, input bit sg, input logic [31:0] a);
    set_op(1, 0, wd, sg, a, 32'h0, 5'd7, 1, 1);
    tick();
  endtask

  initial begin
    rst_n = 0; stall = 0; halt = 0; du_addr = 8'h08;
    set_op(1, 1, 2'b01, 1, 32'h0000_0124, 32'h7777_7777, 5'd31, 1, 1);
    repeat (3) tick();
    chk("rst_read_data", o_rd, 0);
    chk("rst_alu_result", o_alu, 0);
    chk("rst_du_data", o_du, 0);
    chk("rst_ctrl", {o_wreg, o_m2r, o_rw, o_mis}, 0);

    rst_n = 1;
    set_op(0, 0, 2'b11, 0, 32'h10, 32'h0, 5'd0, 0, 0);
    tick();
    chk("idle_alu", o_alu, 32'h10);
    chk("idle_rd", o_rd, 0);

    set_op(0, 1, 2'b11, 0, 32'h20, 32'hDEADBEEF, 5'd0, 0, 0); tick();
    set_op(0, 1, 2'b11, 0, 32'h40, 32'h12345678, 5'd0, 0, 0); tick();
    load(2'b11, 0, 32'h20);
    chk("lw_data", o_rd, 32'hDEADBEEF);
    chk("lw_ctrl", {o_wreg, o_m2r, o_rw, o_mis}, {5'd7, 1'b1, 1'b1, 1'b0});

    load(2'b00, 1, 32'h21); chk("lb_sign", o_rd, 32'hFFFFFFBE);
    load(2'b00, 0, 32'h21); chk("lb_zero", o_rd, 32'h000000BE);
    load(2'b01, 1, 32'h22); chk("lh_sign", o_rd, 32'hFFFFDEAD);
    load(2'b01, 0, 32'h20); chk("lh_zero", o_rd, 32'h0000BEEF);

    set_op(0, 1, 2'b00, 0, 32'h23, 32'hAABBCC11, 5'd0, 0, 0); tick();
    load(2'b11, 0, 32'h20); chk("sb_word", o_rd, 32'h11ADBEEF);
    set_op(0, 1, 2'b01, 0, 32'h20, 32'h99882233, 5'd0, 0, 0); tick();
    load(2'b11, 0, 32'h20); chk("sh_word", o_rd, 32'h11AD2233);

    set_op(0, 1, 2'b11, 0, 32'h22, 32'hFFFFFFFF, 5'd4, 0, 1); tick();
    chk("sw_mis_flag", 32'(o_mis), 1);
    chk("sw_mis_rw", 32'(o_rw), 1);
    load(2'b11, 0, 32'h20); chk("sw_mis_nowrite", o_rd, 32'h11AD2233);
    load(2'b01, 1, 32'h21);
    chk("lh_mis_rd", o_rd, 0);
    chk("lh_mis_flags", {o_rw, o_mis}, 2'b01);

    set_op(1, 0, 2'b11, 0, 32'h20, 32'h0, 5'd9, 1, 1); tick();
    stall = 1;
    set_op(0, 1, 2'b11, 0, 32'h40, 32'hCAFEF00D, 5'd3, 0, 1);
    tick(); tick();
    chk("stall_alu", o_alu, 32'h20);
    chk("stall_rd", o_rd, 32'h11AD2233);
    chk("stall_wreg", 32'(o_wreg), 9);
    stall = 0;
    load(2'b11, 0, 32'h40);
    chk("stall_nowrite", o_rd, 32'h12345678);

    halt = 1; du_addr = 8'h08;
    set_op(0, 1, 2'b11, 0, 32'h20, 32'h0BADBAD0, 5'd2, 0, 1); tick();
    chk("halt_du", o_du, 32'h11AD2233);
    chk("halt_alu", o_alu, 32'h40);
    du_addr = 8'h10; tick();
    chk("halt_du2", o_du, 32'h12345678);
    halt = 0; du_addr = 8'h08;

    set_op(1, 1, 2'b11, 0, 32'h44, 32'h55, 5'd1, 0, 1); tick();
    chk("rdwr_rd", o_rd, 0);
    load(2'b11, 0, 32'h44); chk("rdwr_stored", o_rd, 32'h55);

    set_op(0, 1, 2'b10, 0, 32'h48, 32'h0BADF00D, 5'd0, 0, 0); tick();
    load(2'b10, 1, 32'h48); chk("rsv_word", o_rd, 32'h0BADF00D);
    load(2'b10, 0, 32'h4A); chk("rsv_mis", {o_rd[0], o_mis}, 2'b01);

    set_op(0, 1, 2'b11, 0, 32'h44C, 32'h600DCAFE, 5'd0, 0, 0); tick();
    load(2'b11, 0, 32'h4C); chk("wrap_word", o_rd, 32'h600DCAFE);

    set_op(0, 1, 2'b11, 0, 32'h20, 32'hA5A5A5A5, 5'd6, 1, 1);
    #2 rst_n = 0;
    #1 chk("async_rst_alu", o_alu, 0);
    chk("async_rst_du", o_du, 0);
    tick();
    rst_n = 1;
    load(2'b11, 0, 32'h20); chk("rst_discard", o_rd, 32'h11AD2233);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
